seq_detect_ctrl: RTL and testbench

//   Programmable serial bit-pattern detection controller. It sequences one detection
//   run at a time: latch the config on start, scan a window of valid serial bits,

---
 rtl/seq_detect_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Programmable serial bit-pattern detection controller. A run is started by a
//   one-cycle start pulse in IDLE. In LOAD the configuration is latched into shadow
//   registers. In RUN, cfg_window valid serial bits are scanned and pattern hits are
//   counted. DONE then raises done for one cycle. Matching is overlapping or
//   non-overlapping, for patterns of 0..MAXLEN bits.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        run request, honoured only in IDLE
//   cfg_pattern  pattern, bit [len-1] received first, bit [0] last
//   cfg_len      pattern length (clamped to MAXLEN at LOAD, 0 never matches)
//   cfg_overlap  1 = overlapping matches, 0 = restart after each hit
//   cfg_window   number of valid bits to scan
//   in_valid     qualifies in
//   in           serial data bit
//   busy         high in LOAD and RUN
//   match        one-cycle pulse per detected pattern
//   match_count  saturating hit count; holds after DONE until the next LOAD
//   done         one-cycle pulse at end of a completed run
module seq_detect_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned LW     = 4,
  parameter int unsigned CW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CW-1:0]     cfg_window,
  input  logic              in_valid,
  input  logic              in,
  output logic              busy,
  output logic              match,
  output logic [CW-1:0]     match_count,
  output logic              done
);

  // One extra bit so that fill+1 never wraps in the length comparison
  localparam int unsigned FW = LW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // State and shadow configuration
  state_t              r_state;
  logic [MAXLEN-1:0]   r_pat;
  logic [LW-1:0]       r_len;
  logic                r_ovl;
  logic [CW-1:0]       r_win;

  // Datapath registers
  logic [MAXLEN-1:0]   r_hist;
  logic [LW-1:0]       r_fill;
  logic [CW-1:0]       r_bits;

  // Registered outputs
  logic                r_busy;
  logic                r_match;
  logic [CW-1:0]       r_count;
  logic                r_done;

  // Next-state values
  state_t              w_state_nxt;
  logic [MAXLEN-1:0]   w_pat_nxt;
  logic [LW-1:0]       w_len_nxt;
  logic                w_ovl_nxt;
  logic [CW-1:0]       w_win_nxt;
  logic [MAXLEN-1:0]   w_hist_nxt;
  logic [LW-1:0]       w_fill_nxt;
  logic [CW-1:0]       w_bits_nxt;
  logic                w_busy_nxt;
  logic                w_match_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic                w_done_nxt;

  // Combinational helpers
  logic [LW-1:0]       w_len_clamped;
  logic [MAXLEN-1:0]   w_mask;
  logic [MAXLEN-1:0]   w_hist_shift;
  logic [FW-1:0]       w_fill_inc;
  logic [CW-1:0]       w_bits_inc;
  logic                w_hit;
  logic                w_last;

  assign w_len_clamped = (cfg_len > LW'(MAXLEN)) ? LW'(MAXLEN) : cfg_len;

  // Mask selecting the low r_len bits of history/pattern for comparison
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      w_mask[i] = (LW'(i) < r_len);
    end
  end

  assign w_hist_shift = {r_hist[MAXLEN-2:0], in};
  assign w_fill_inc   = FW'(r_fill) + FW'(1);
  assign w_bits_inc   = r_bits + CW'(1);
  assign w_last       = (w_bits_inc == r_win);

  // A hit needs len bits since the last restart and equal low len bits
  assign w_hit = (r_len != '0) &&
                 (w_fill_inc >= FW'(r_len)) &&
                 (((w_hist_shift ^ r_pat) & w_mask) == '0);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_ovl_nxt   = r_ovl;
    w_win_nxt   = r_win;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_bits_nxt  = r_bits;
    w_count_nxt = r_count;
    w_match_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        w_pat_nxt   = cfg_pattern;
        w_len_nxt   = w_len_clamped;
        w_ovl_nxt   = cfg_overlap;
        w_win_nxt   = cfg_window;
        w_hist_nxt  = '0;
        w_fill_nxt  = '0;
        w_bits_nxt  = '0;
        w_count_nxt = '0;
        w_state_nxt = (cfg_window == '0) ? S_DONE : S_RUN;
      end

      S_RUN: begin
        if (in_valid) begin
          w_hist_nxt = w_hist_shift;
          w_bits_nxt = w_bits_inc;
          if (r_fill >= LW'(MAXLEN)) begin
            w_fill_nxt = r_fill;
          end else begin
            w_fill_nxt = r_fill + LW'(1);
          end
          if (w_hit) begin
            w_match_nxt = 1'b1;
            if (r_count != '1) begin
              w_count_nxt = r_count + CW'(1);
            end
            // Non-overlap: the next hit must be built from fresh bits only
            if (!r_ovl) begin
              w_fill_nxt = '0;
            end
          end
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Status outputs are registered from the state being entered
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_win   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
      r_match <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_ovl   <= w_ovl_nxt;
      r_win   <= w_win_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_bits  <= w_bits_nxt;
      r_busy  <= w_busy_nxt;
      r_match <= w_match_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy        = r_busy;
  assign match       = r_match;
  assign match_count = r_count;
  assign done        = r_done;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: directed vector table, hand-written reset and
// saturation sequences, and randomized runs checked against a behavioural model.
module tb_seq_detect_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [15:0] cfg_window;
  logic        in_valid;
  logic        in;
  logic        busy;
  logic        match;
  logic [15:0] match_count;
  logic        done;
  logic        s_busy;
  logic        s_match;
  logic [3:0]  s_count;
  logic        s_done;

  int n_total = 0;
  int n_pass  = 0;

  bit stim_v[$];
  bit stim_b[$];

  seq_detect_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window), .in_valid(in_valid), .in(in),
    .busy(busy), .match(match), .match_count(match_count), .done(done)
  );

  // Narrow-counter instance for the saturation case
  seq_detect_ctrl #(.CW(4)) u_sat (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_window(cfg_window[3:0]), .in_valid(in_valid), .in(in),
    .busy(s_busy), .match(s_match), .match_count(s_count), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clock with the given serial input; returns #1 after the edge
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  // Full run: model expectations derived from the accepted bit list
  task automatic run_seq(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic [15:0] win, input int exp_cnt, input string nm);
    int  L;
    bit  acc[$];
    int  rs;
    int  cnt;
    int  seen;
    int  k;
    bit  hit;
    L    = (len > 4'd8) ? 8 : int'(len);
    rs   = 0;
    cnt  = 0;
    seen = 0;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_window  = win;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_load_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    if (win == 16'd0) begin
      chk({nm, "_w0_done"}, 32'(done), 32'd1);
      chk({nm, "_w0_busy"}, 32'(busy), 32'd0);
    end else begin
      chk({nm, "_run_busy"}, 32'(busy), 32'd1);
      chk({nm, "_run_cnt0"}, 32'(match_count), 32'd0);
      for (int i = 0; i < stim_v.size() && seen < int'(win); i++) begin
        step(stim_v[i], stim_b[i]);
        hit = 1'b0;
        if (stim_v[i]) begin
          acc.push_back(stim_b[i]);
          seen++;
          k = acc.size();
          if (L > 0 && (k - rs) >= L) begin
            hit = 1'b1;
            for (int j = 0; j < L; j++)
              if (acc[k - L + j] != pat[L - 1 - j]) hit = 1'b0;
          end
          if (hit) begin
            if (cnt < 65535) cnt++;
            if (!ovl) rs = k;
          end
        end
        chk({nm, "_match"}, 32'(match), 32'(hit));
        chk({nm, "_done"}, 32'(done), 32'(seen == int'(win)));
      end
      in_valid = 1'b0;
      if (seen < int'(win))
        chk({nm, "_stim_short"}, 32'(seen), 32'(win));
    end
    chk({nm, "_cnt"}, 32'(match_count), 32'(cnt));
    if (exp_cnt >= 0) chk({nm, "_cnt_tbl"}, 32'(match_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
    chk({nm, "_post_done"}, 32'(done), 32'd0);
    chk({nm, "_post_busy"}, 32'(busy), 32'd0);
    chk({nm, "_post_hold"}, 32'(match_count), 32'(cnt));
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic [15:0] win;
    logic [15:0] vmask;
    logic [15:0] bmask;
    int          ncyc;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // {pat, len, ovl, window, valid-per-cycle, bit-per-cycle, cycles, expected count}
    vecs[0] = '{8'h05, 4'd3,  1'b1, 16'd5,  16'h001F, 16'h0015, 5,  2}; // overlap 10101
    vecs[1] = '{8'h05, 4'd3,  1'b0, 16'd5,  16'h001F, 16'h0015, 5,  1}; // non-overlap
    vecs[2] = '{8'h05, 4'd3,  1'b1, 16'd3,  16'h0025, 16'h0021, 6,  1}; // gaps
    vecs[3] = '{8'h05, 4'd3,  1'b1, 16'd0,  16'h0000, 16'h0000, 0,  0}; // zero window
    vecs[4] = '{8'hA5, 4'd15, 1'b1, 16'd10, 16'h03FF, 16'h01A5, 10, 1}; // len clamp
    vecs[5] = '{8'h01, 4'd1,  1'b0, 16'd4,  16'h000F, 16'h000B, 4,  3}; // len 1
    vecs[6] = '{8'h00, 4'd0,  1'b1, 16'd4,  16'h000F, 16'h000F, 4,  0}; // len 0
    vecs[7] = '{8'h07, 4'd3,  1'b0, 16'd7,  16'h007F, 16'h007F, 7,  2}; // 111 non-overlap

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_window = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    rst = 1'b1;
    step(1'b0, 1'b0);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      stim_v.delete();
      stim_b.delete();
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        stim_v.push_back(vecs[v].vmask[c]);
        stim_b.push_back(vecs[v].bmask[c]);
      end
      run_seq(vecs[v].pat, vecs[v].len, vecs[v].ovl, vecs[v].win, vecs[v].exp_cnt,
              $sformatf("vec%0d", v));
      step(1'b0, 1'b0);
    end

    // Ignored start during RUN, then async reset mid-run after two hits
    cfg_pattern = 8'h05; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_window = 16'd10;
    start = 1'b1;
    step(1'b0, 1'b0);
    start = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b1);
    chk("abort_hits", 32'(match_count), 32'd2);
    start = 1'b1;
    step(1'b0, 1'b0);
    start = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("busy_start_ign_cnt", 32'(match_count), 32'd2);
    chk("busy_start_ign_busy", 32'(busy), 32'd1);
    #3;
    rst   = 1'b0;
    start = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_match", 32'(match), 32'd0);
    chk("abort_cnt", 32'(match_count), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    stim_v.delete();
    stim_b.delete();
    for (int c = 0; c < 5; c++) begin
      stim_v.push_back(1'b1);
      stim_b.push_back(vecs[0].bmask[c]);
    end
    run_seq(8'h05, 4'd3, 1'b1, 16'd5, 2, "after_rst");
    step(1'b0, 1'b0);

    // Saturation on the 4-bit counter, then clear at the next LOAD
    stim_v.delete();
    stim_b.delete();
    for (int c = 0; c < 15; c++) begin
      stim_v.push_back(1'b1);
      stim_b.push_back(1'b1);
    end
    run_seq(8'h01, 4'd1, 1'b1, 16'd15, 15, "sat");
    chk("sat_cnt4", 32'(s_count), 32'd15);
    step(1'b0, 1'b0);
    stim_v.delete();
    stim_b.delete();
    run_seq(8'h01, 4'd1, 1'b1, 16'd0, 0, "sat_clr");
    chk("sat_cnt4_clr", 32'(s_count), 32'd0);
    step(1'b0, 1'b0);

    // Randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      logic [7:0]  rp;
      logic [3:0]  rl;
      logic        ro;
      logic [15:0] rw;
      int          nv;
      rp = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      ro = 1'($urandom);
      rw = 16'($urandom_range(0, 40));
      stim_v.delete();
      stim_b.delete();
      nv = 0;
      while (nv < int'(rw)) begin
        stim_v.push_back($urandom_range(0, 3) != 0);
        stim_b.push_back(1'($urandom));
        if (stim_v[stim_v.size() - 1]) nv++;
      end
      run_seq(rp, rl, ro, rw, -1, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
